// File: rtl/multi_clk_div_if.sv
// Divisor-load handshake bundle for multi_clk_div.
// The master drives a load request; the slave (divider) answers with cfg_ready.
interface multi_clk_div_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 26
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..div and strobes tick on the terminal count; clk_out either toggles
// there (mode 0) or mirrors tick (mode 1). New divisors are staged in a pending slot and
// swapped in at the channel's next terminal (or immediately when the channel is disabled),
// so a period is never shortened.
// Optional: define CLKDIV_EVENT_CNT_EN to add ev_cnt, an 8-bit wrapping terminal counter per
// channel.
module multi_clk_div #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CW          = 26,
  parameter int unsigned DEFAULT_DIV = 22_000_000
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [NCH-1:0]     en,
  input  logic [NCH-1:0]     mode,
  multi_clk_div_if.slave     cfg,
  output logic [NCH-1:0]     clk_out,
  output logic [NCH-1:0]     tick
`ifdef CLKDIV_EVENT_CNT_EN
  ,
  output logic [NCH*8-1:0]   ev_cnt
`endif
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] div_q, div_d;
  logic [NCH-1:0][CW-1:0] pdiv_q, pdiv_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic [NCH-1:0]         clk_q, clk_d;
  logic [NCH-1:0]         term;
  logic                   cfg_fire;
`ifdef CLKDIV_EVENT_CNT_EN
  logic [NCH-1:0][7:0]    ev_q, ev_d;
`endif

  // Back-pressure only a valid channel that already holds an unapplied divisor.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i) && pend_q[i]) cfg.cfg_ready = 1'b0;
    end
  end

  assign cfg_fire = cfg.cfg_valid && cfg.cfg_ready;

  // Per-channel next state: counter, strobe, output, divisor staging.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    tick_d = '0;
    clk_d  = '0;
    term   = '0;
`ifdef CLKDIV_EVENT_CNT_EN
    ev_d   = ev_q;
`endif
    for (int i = 0; i < NCH; i++) begin
      term[i] = en[i] && (cnt_q[i] == div_q[i]);
      if (en[i]) begin
        cnt_d[i]  = term[i] ? '0 : cnt_q[i] + CW'(1);
        tick_d[i] = term[i];
        clk_d[i]  = mode[i] ? term[i] : (clk_q[i] ^ term[i]);
      end else begin
        cnt_d[i] = '0;
      end
      // Swap uses the pending value from before this edge, so a load that lands on a
      // terminal waits for the following one.
      if (pend_q[i] && (term[i] || !en[i])) begin
        div_d[i]  = pdiv_q[i];
        pend_d[i] = 1'b0;
      end
      if (cfg_fire && cfg.cfg_ch == CHW'(i)) begin
        pdiv_d[i] = cfg.cfg_div;
        pend_d[i] = 1'b1;
      end
`ifdef CLKDIV_EVENT_CNT_EN
      if (term[i]) ev_d[i] = ev_q[i] + 8'd1;
`endif
    end
  end

  // State registers; reset restores the default divisor and drops staged loads.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= {NCH{CW'(DEFAULT_DIV)}};
      pdiv_q <= '0;
      pend_q <= '0;
      tick_q <= '0;
      clk_q  <= '0;
`ifdef CLKDIV_EVENT_CNT_EN
      ev_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
`ifdef CLKDIV_EVENT_CNT_EN
      ev_q   <= ev_d;
`endif
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
`ifdef CLKDIV_EVENT_CNT_EN
  assign ev_cnt  = ev_q;
`endif

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div (NCH=4, CW=8, DEFAULT_DIV=3) plus a 5-channel instance
// used to exercise loads addressed beyond the last channel.
module tb_multi_clk_div;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] en, mode, clk_out, tick;
  logic [4:0] en5, mode5, clk_out5, tick5;
`ifdef CLKDIV_EVENT_CNT_EN
  logic [31:0] ev_cnt;
  logic [39:0] ev_cnt5;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic exp_t, exp_clk;

  always #5 clk_in = ~clk_in;

  multi_clk_div_if #(.NCH(4), .CW(8)) cfg_if ();
  multi_clk_div_if #(.NCH(5), .CW(8)) cfg5_if ();

  multi_clk_div #(.NCH(4), .CW(8), .DEFAULT_DIV(3)) u_dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
`ifdef CLKDIV_EVENT_CNT_EN
    ,
    .ev_cnt  (ev_cnt)
`endif
  );

  multi_clk_div #(.NCH(5), .CW(8), .DEFAULT_DIV(3)) u_dut5 (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en5),
    .mode    (mode5),
    .cfg     (cfg5_if),
    .clk_out (clk_out5),
    .tick    (tick5)
`ifdef CLKDIV_EVENT_CNT_EN
    ,
    .ev_cnt  (ev_cnt5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    en = '0; mode = '0; en5 = '0; mode5 = '0;
    cfg_if.cfg_valid  = 1'b0; cfg_if.cfg_ch  = '0; cfg_if.cfg_div  = '0;
    cfg5_if.cfg_valid = 1'b0; cfg5_if.cfg_ch = '0; cfg5_if.cfg_div = '0;
    repeat (2) step();
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    en  = 4'b0001;
    en5 = 5'h1f;
    step();
    rst = 1'b0;

    // Default divisor 3: tick every 4 cycles, clk_out[0] period 8, other channels idle.
    for (int k = 1; k <= 16; k++) begin
      step();
      check("p1_tick", tick, (k % 4 == 0) ? 1 : 0);
      check("p1_clk", clk_out, (k / 4) % 2);
      check("p1_tick5", tick5, (k % 4 == 0) ? 5'h1f : 5'h00);
      if (k == 5) begin
        cfg5_if.cfg_valid = 1'b1; cfg5_if.cfg_ch = 3'd5; cfg5_if.cfg_div = 8'd0;
        #1 check("ready_ch5", cfg5_if.cfg_ready, 1);
      end
      if (k == 6) begin
        cfg5_if.cfg_valid = 1'b0; cfg5_if.cfg_ch = 3'd0;
      end
      if (k == 7) check("ready5_after_discard", cfg5_if.cfg_ready, 1);
    end

    // Mid-period load of div=1: period in flight stays 4, then 2; second load blocked.
    exp_clk = 1'b0;
    for (int k = 17; k <= 28; k++) begin
      step();
      exp_t = (k == 20) || (k > 20 && k % 2 == 0);
      if (exp_t) exp_clk = ~exp_clk;
      check("p2_tick0", tick[0], exp_t);
      check("p2_clk0", clk_out[0], exp_clk);
      if (k == 18) begin
        check("ready_idle", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd1;
      end
      if (k == 19) begin
        cfg_if.cfg_div = 8'd2;
        #1 check("ready_busy", cfg_if.cfg_ready, 0);
      end
      if (k == 20) cfg_if.cfg_valid = 1'b0;
    end

    // Load accepted on the terminal at 30 applies at 32, not 30.
    for (int k = 29; k <= 40; k++) begin
      step();
      exp_t = (k == 30) || (k == 32) || (k == 36) || (k == 40);
      if (exp_t) exp_clk = ~exp_clk;
      check("p3_tick0", tick[0], exp_t);
      check("p3_clk0", clk_out[0], exp_clk);
      if (k == 29) begin
        check("ready_coincident", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd3;
      end
      if (k == 30) cfg_if.cfg_valid = 1'b0;
    end

    // ch0 switches to pulse mode while high; ch1 gets div=0 in pulse mode then disabled.
    mode[0] = 1'b1;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd0;
    for (int k = 41; k <= 48; k++) begin
      step();
      check("p4_tick0", tick[0], (k == 44 || k == 48) ? 1 : 0);
      check("p4_clk0", clk_out[0], (k == 44 || k == 48) ? 1 : 0);
      check("p4_tick1", tick[1], (k >= 43 && k <= 46) ? 1 : 0);
      check("p4_clk1", clk_out[1], (k >= 43 && k <= 46) ? 1 : 0);
      if (k == 41) cfg_if.cfg_valid = 1'b0;
      if (k == 42) begin en[1] = 1'b1; mode[1] = 1'b1; end
      if (k == 45) mode[0] = 1'b0;
      if (k == 46) en[1] = 1'b0;
    end

    // Asynchronous reset between edges with a load pending on ch0.
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 8'd1;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("busy_before_rst", cfg_if.cfg_ready, 0);
    #3;
    check("clk0_before_rst", clk_out[0], 1);
    rst = 1'b1;
    #1;
    check("async_rst_clk", clk_out, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_ready", cfg_if.cfg_ready, 1);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("p5_tick0", tick[0], (k % 4 == 0) ? 1 : 0);
    end

`ifdef CLKDIV_EVENT_CNT_EN
    // div=0 on ch2: 256 terminals wrap its event count back to 0; ch0 held when disabled.
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    en = 4'b0100;
    repeat (255) step();
    check("ev_ch2_255", ev_cnt[23:16], 255);
    step();
    check("ev_ch2_wrap", ev_cnt[23:16], 0);
    check("ev_ch0_held", ev_cnt[7:0], 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CW, default 26, divisor/counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 22_000_000, per-channel divisor after reset; SHALL fit in CW bits.
REQ-004 clk_in  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  NCH  per-channel enable, bit i = channel i.
REQ-007 mode  input  NCH  per-channel output mode: 0 = toggle (square wave), 1 = pulse (one-cycle high).
REQ-008 cfg_valid  input  1  divisor-load request.
REQ-009 cfg_ch  input  max(1,$clog2(NCH))  target channel of load.
REQ-010 cfg_div  input  CW  new divisor value.
REQ-011 cfg_ready  output  1  load accepted when cfg_valid and cfg_ready are both high on a clock edge.
REQ-012 clk_out  output  NCH  registered divided output per channel.
REQ-013 tick  output  NCH  registered one-cycle strobe at each terminal count, independent of mode.

Function
REQ-014 Each channel SHALL hold a CW-bit counter, an active divisor, a pending divisor and a pending flag.
REQ-015 While en[i]=1, counter SHALL increment by 1 per cycle; when counter equals active divisor (terminal), counter SHALL return to 0 on the next edge; event period = div+1 cycles.
REQ-016 On terminal, tick[i] SHALL be 1 for exactly the following cycle; otherwise 0.
REQ-017 Mode 0: clk_out[i] SHALL invert on each terminal; output period = 2*(div+1) cycles.
REQ-018 Mode 1: clk_out[i] SHALL equal tick[i].
REQ-019 Mode change SHALL take effect the cycle after it is sampled; switching 0->1 with clk_out high SHALL drive clk_out low on the next cycle unless that cycle is a terminal strobe.
REQ-020 div=0 SHALL be legal: terminal every cycle, tick constantly 1, toggle mode gives clk_in/2.
REQ-021 While en[i]=0: counter SHALL be held at 0, tick[i]=0, clk_out[i]=0; first terminal after en rises SHALL occur div+1 cycles after the first enabled edge.
REQ-022 cfg_ready SHALL be 0 only when cfg_ch addresses a valid channel whose pending flag is set; combinational from cfg_ch and pending flags.
REQ-023 Accepted load SHALL write cfg_div to the pending divisor and set the pending flag.
REQ-024 Pending divisor SHALL be copied to active divisor and flag cleared at the channel's next terminal, or on the next edge if en[i]=0; no output glitch or short period SHALL result.
REQ-025 Load accepted in the same cycle as a terminal on that channel SHALL NOT apply at that terminal; it applies at the following terminal.
REQ-026 Load with cfg_ch >= NCH SHALL be accepted (cfg_ready=1) and discarded.
REQ-027 Channels SHALL be fully independent; simultaneous terminals on several channels SHALL all be serviced in the same cycle.

Reset
REQ-028 rst=1 SHALL immediately clear all counters, clk_out, tick and pending flags, and load DEFAULT_DIV into every active divisor, independent of clk_in.
REQ-029 After rst deasserts, first terminal on an enabled channel SHALL occur DEFAULT_DIV+1 cycles later; cfg_ready SHALL be 1.
REQ-030 rst asserted mid-period or with a load pending SHALL discard all in-flight state.

Configuration
REQ-031 Macro CLKDIV_EVENT_CNT_EN defined: module SHALL add output ev_cnt (NCH*8 bits), channel i in bits [8i+7:8i], an 8-bit wrapping count of terminals (255->0), cleared by rst and held while en[i]=0.
REQ-032 Macro undefined: ev_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 NCH=4, CW=8, DEFAULT_DIV=3, en=4'b0001, mode=0, release reset -> clk_out[0] period 8 cycles, tick[0] every 4 cycles, other channels 0.
REQ-034 Load cfg_ch=0, cfg_div=1 mid-period -> next period still 4 cycles, subsequent periods 2 cycles; second load to ch0 before apply sees cfg_ready=0.
REQ-035 mode[1]=1, div=0, en[1]=1 -> clk_out[1] and tick[1] constantly 1; en[1]=0 -> both 0 next cycle.
REQ-036 Load coincident with ch0 terminal -> new divisor applied one terminal later; cfg_ch=5 load -> cfg_ready=1, no channel changes.
REQ-037 Assert rst asynchronously between clock edges with pending load -> outputs 0 immediately, divisor reverts to 3, pending lost.
REQ-038 With CLKDIV_EVENT_CNT_EN, div=0 for 256 cycles -> ev_cnt[7:0] wraps to 0.
